veggie_slice_ctrl: RTL
======================

// Module: veggie_slice_ctrl
// PURPOSE
// Per-veggie sequencer that drives one split-sprite renderer pair (top/bottom halves).
// - Launches a veggie from the bottom of the screen and integrates simple per-frame physics.
// - Detects a blade slice, latches the cut slope, drives the two halves apart and retires the veggie off-screen.
// - Sits between the game FSM (launch/slice events) and the sprite renderers (positions, whole/split select, slope).
// PARAMETERS
// WIDTH     256   sprite width in pixels (power of 2)
// HEIGHT    256   sprite height in pixels (power of 2)
// SCREEN_W  1024  visible width
// SCREEN_H  768   visible height
// GRAVITY   1     added to vertical velocity each frame (px/frame^2)
// SEP_VX    2     horizontal separation speed added/subtracted on split
// PORTS
// pixel_clk_in     in   1    pixel clock; single clock domain
// rst_in           in   1    asynchronous, active-low reset
// new_frame_in     in   1    1-cycle pulse once per frame (end of active video)
// launch_in        in   1    1-cycle pulse: start a veggie (ignored unless IDLE)
// launch_x_in      in   11   launch centre x
// launch_vx_in     in   8    signed initial x velocity
// launch_vy_in     in   8    signed initial y velocity (negative = up)
// slice_valid_in   in   1    1-cycle pulse: blade stroke sample
// slice_x_in       in   11   blade x
// slice_y_in       in   10   blade y
// slice_run_in     in   11   blade line run (dx)
// slice_rise_in    in   10   blade line rise (dy)
// x_top_out        out  11   top-half centre x  | y_top_out  out 10  top-half centre y
// x_bot_out        out  11   bottom-half centre x | y_bot_out out 10 bottom-half centre y
// whole_out        out  1    1 = render unsplit sprite; 0 = render halves
// run_out          out  11   latched cut run, never 0
// rise_out         out  10   latched cut rise
// visible_out      out  1    1 = renderers enabled
// sliced_out       out  1    1-cycle pulse on successful slice (score)
// gone_out         out  1    1-cycle pulse when veggie retires
// busy_out         out  1    high in any state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE; all positions 0; whole_out=1; run_out=1; rise_out=0; visible_out, sliced_out, gone_out, busy_out = 0.
// - States: IDLE -> FLYING (launch_in) -> SPLIT (hit) -> IDLE (off-screen, gone_out pulse).
//   FLYING -> IDLE directly when the veggie falls off-screen uncut (gone_out pulses, sliced_out does not).
// - Launch: x=launch_x_in, y=SCREEN_H+HEIGHT/2, vx/vy latched; both halves share the same position; whole_out=1; visible_out=1.
// - Per frame (new_frame_in) in FLYING/SPLIT:
//   x += vx; y += vy; vy += GRAVITY; vy saturates at +/-127.
//   Positions held internally as signed 13-bit; outputs are the low bits, valid only when visible_out=1.
//   Top clamp: if new y < 0, then y=0 and vy=0.
// - Hit (FLYING only), evaluated against the pre-update position:
//   |slice_x-x| < WIDTH/2 && |slice_y-y| < HEIGHT/2.
//   On hit: run_out = (slice_run_in==0) ? 1 : slice_run_in; rise_out = slice_rise_in; whole_out=0; sliced_out pulses next cycle.
//   Top half takes vx_top = vx - SEP_VX; bottom half takes vx_bot = vx + SEP_VX; both halves share vy.
// - Retire: in FLYING, retire when vy>0 and y > SCREEN_H+HEIGHT/2.
//   In SPLIT, retire when both halves meet that condition, or both x are outside [-WIDTH/2, SCREEN_W+WIDTH/2).
// - Latency: outputs are registered and update 1 cycle after new_frame_in or slice_valid_in.
// - Simultaneous slice_valid_in and new_frame_in: hit is tested first; the frame update then applies the split velocities in the same cycle.
// - Further slices in SPLIT are ignored; launch_in while busy is ignored.
// - Asynchronous reset mid-flight returns to the reset values immediately; no gone_out pulse.
// STRUCTURE
// - Shared package veggie_pkg: state enum, SCREEN_W/SCREEN_H, velocity/position widths, sat_add function.
// - One sub-module, veggie_physics: per-frame integrator (x, y, vx, vy, with clamp and saturation), instantiated twice (top, bottom).
//   Before the split, both instances are loaded identically.
// TESTING
// 1 Reset asserted mid-FLYING -> IDLE, whole_out=1, visible_out=0, no gone_out.
// 2 launch x=512 vx=0 vy=-20, 40 frames -> y falls to 768+128-sum(20..1)=686 at apex, vy=0 after frame 20.
// 3 Hit at frame 10 with slice (x+5, y-3) run=10 rise=5 -> whole_out=0, run_out=10, rise_out=5, sliced_out for 1 cycle;
//   halves' x diverge by 4 px per frame.
// 4 Slice with run=0 on hit -> run_out=1; a slice 200 px away -> no state change.
// 5 Uncut veggie falls below 896 with vy>0 -> single gone_out pulse, busy_out=0; launch_in during flight ignored.
// 6 slice_valid_in coincident with new_frame_in -> hit uses the old position; split velocities apply in that frame.

Source files
------------

// File: rtl/veggie_pkg.sv
// rtl/veggie_pkg.sv - shared types, screen geometry and saturating velocity helpers
package veggie_pkg;

  localparam int WIDTH    = 256;
  localparam int HEIGHT   = 256;
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int GRAVITY  = 1;
  localparam int SEP_VX   = 2;

  localparam int POS_W   = 13;
  localparam int VEL_W   = 8;
  localparam int VEL_MAX = 127;
  localparam int HALF_W  = WIDTH / 2;
  localparam int HALF_H  = HEIGHT / 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLYING = 2'd1,
    ST_SPLIT  = 2'd2
  } state_t;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  // Launch line: sprite centre just below the bottom edge; also the exit line.
  localparam pos_t LAUNCH_Y = pos_t'(SCREEN_H + HALF_H);
  localparam pos_t X_MIN    = pos_t'(-HALF_W);
  localparam pos_t X_LIMIT  = pos_t'(SCREEN_W + HALF_W);
  localparam vel_t SEP_POS  = vel_t'(SEP_VX);
  localparam vel_t SEP_NEG  = vel_t'(-SEP_VX);

  localparam logic signed [VEL_W:0] SUM_HI = (VEL_W+1)'(VEL_MAX);
  localparam logic signed [VEL_W:0] SUM_LO = (VEL_W+1)'(-VEL_MAX);

  // Symmetric saturation keeps velocities inside +/-127.
  function automatic vel_t sat_add(input vel_t a, input vel_t b);
    logic signed [VEL_W:0] sum;
    sum = {a[VEL_W-1], a} + {b[VEL_W-1], b};
    if (sum > SUM_HI) begin
      return vel_t'(VEL_MAX);
    end else if (sum < SUM_LO) begin
      return vel_t'(-VEL_MAX);
    end
    return sum[VEL_W-1:0];
  endfunction

  function automatic pos_t vel_to_pos(input vel_t v);
    return {{(POS_W-VEL_W){v[VEL_W-1]}}, v};
  endfunction

  function automatic logic below_exit(input pos_t y, input vel_t vy);
    return (y > LAUNCH_Y) && (vy > vel_t'(0));
  endfunction

  function automatic logic off_side(input pos_t x);
    return (x < X_MIN) || (x >= X_LIMIT);
  endfunction

endpackage

// File: rtl/veggie_physics.sv
// rtl/veggie_physics.sv - per-frame integrator for one sprite half
module veggie_physics
  import veggie_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  pos_t load_x,
  input  pos_t load_y,
  input  vel_t load_vx,
  input  vel_t load_vy,
  input  logic kick,
  input  vel_t kick_dvx,
  input  logic step,
  output pos_t x,
  output pos_t y,
  output pos_t x_nxt,
  output pos_t y_nxt,
  output vel_t vy_nxt
);

  pos_t x_q, x_d, y_q, y_d, y_raw;
  vel_t vx_q, vx_d, vy_q, vy_d;

  // Load on launch; otherwise apply any split kick first, then one frame of motion.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    vx_d  = vx_q;
    vy_d  = vy_q;
    y_raw = y_q;
    if (load) begin
      x_d  = load_x;
      y_d  = load_y;
      vx_d = load_vx;
      vy_d = load_vy;
    end else begin
      if (kick) begin
        vx_d = sat_add(vx_q, kick_dvx);
      end
      if (step) begin
        x_d   = x_q + vel_to_pos(vx_d);
        y_raw = y_q + vel_to_pos(vy_q);
        vy_d  = sat_add(vy_q, vel_t'(GRAVITY));
        if (y_raw[POS_W-1]) begin
          y_d  = '0;
          vy_d = '0;
        end else begin
          y_d = y_raw;
        end
      end
    end
  end

  // Integrator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      vx_q <= '0;
      vy_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign x_nxt  = x_d;
  assign y_nxt  = y_d;
  assign vy_nxt = vy_d;

endmodule

// File: rtl/veggie_slice_ctrl.sv
// rtl/veggie_slice_ctrl.sv - per-veggie launch / slice / retire sequencer
module veggie_slice_ctrl
  import veggie_pkg::*;
(
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        new_frame_in,
  input  logic        launch_in,
  input  logic [10:0] launch_x_in,
  input  logic [7:0]  launch_vx_in,
  input  logic [7:0]  launch_vy_in,
  input  logic        slice_valid_in,
  input  logic [10:0] slice_x_in,
  input  logic [9:0]  slice_y_in,
  input  logic [10:0] slice_run_in,
  input  logic [9:0]  slice_rise_in,
  output logic [10:0] x_top_out,
  output logic [9:0]  y_top_out,
  output logic [10:0] x_bot_out,
  output logic [9:0]  y_bot_out,
  output logic        whole_out,
  output logic [10:0] run_out,
  output logic [9:0]  rise_out,
  output logic        visible_out,
  output logic        sliced_out,
  output logic        gone_out,
  output logic        busy_out
);

  state_t state_q, state_d;
  logic whole_q, whole_d, visible_q, visible_d, busy_q, busy_d;
  logic sliced_q, sliced_d, gone_q, gone_d;
  logic [10:0] run_q, run_d;
  logic [9:0]  rise_q, rise_d;

  pos_t x_top, y_top, x_bot, y_bot;
  pos_t x_top_nxt, y_top_nxt, x_bot_nxt, y_bot_nxt;
  vel_t vy_top_nxt, vy_bot_nxt;
  logic load, step, hit, split_eff, retire;
  logic signed [POS_W:0] dx, dy, adx, ady;
  logic unused_bot_hi;

  assign load = launch_in && (state_q == ST_IDLE);
  assign step = new_frame_in && (state_q != ST_IDLE);

  // Blade proximity against the pre-update position (halves still coincide while flying).
  always_comb begin
    dx  = {x_top[POS_W-1], x_top} - {3'b000, slice_x_in};
    dy  = {y_top[POS_W-1], y_top} - {4'b0000, slice_y_in};
    adx = dx[POS_W] ? -dx : dx;
    ady = dy[POS_W] ? -dy : dy;
    hit = (state_q == ST_FLYING) && slice_valid_in &&
          (adx < (POS_W+1)'(HALF_W)) && (ady < (POS_W+1)'(HALF_H));
  end

  // Retire on the post-update position; a same-cycle hit already counts as split.
  always_comb begin
    split_eff = (state_q == ST_SPLIT) || hit;
    retire    = (below_exit(y_top_nxt, vy_top_nxt) && below_exit(y_bot_nxt, vy_bot_nxt)) ||
                (split_eff && off_side(x_top_nxt) && off_side(x_bot_nxt));
  end

  // Lifecycle next-state and output values.
  always_comb begin
    state_d   = state_q;
    whole_d   = whole_q;
    run_d     = run_q;
    rise_d    = rise_q;
    visible_d = visible_q;
    busy_d    = busy_q;
    sliced_d  = 1'b0;
    gone_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d   = ST_FLYING;
          whole_d   = 1'b1;
          visible_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_FLYING: begin
        if (hit) begin
          state_d  = ST_SPLIT;
          whole_d  = 1'b0;
          run_d    = (slice_run_in == 11'd0) ? 11'd1 : slice_run_in;
          rise_d   = slice_rise_in;
          sliced_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (step && retire) begin
      state_d   = ST_IDLE;
      visible_d = 1'b0;
      busy_d    = 1'b0;
      gone_d    = 1'b1;
    end
  end

  // Lifecycle state and registered control outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      whole_q   <= 1'b1;
      run_q     <= 11'd1;
      rise_q    <= 10'd0;
      visible_q <= 1'b0;
      busy_q    <= 1'b0;
      sliced_q  <= 1'b0;
      gone_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      whole_q   <= whole_d;
      run_q     <= run_d;
      rise_q    <= rise_d;
      visible_q <= visible_d;
      busy_q    <= busy_d;
      sliced_q  <= sliced_d;
      gone_q    <= gone_d;
    end
  end

  veggie_physics u_top (
    .clk      (pixel_clk_in),
    .rst_n    (rst_in),
    .load     (load),
    .load_x   ({2'b00, launch_x_in}),
    .load_y   (LAUNCH_Y),
    .load_vx  (launch_vx_in),
    .load_vy  (launch_vy_in),
    .kick     (hit),
    .kick_dvx (SEP_NEG),
    .step     (step),
    .x        (x_top),
    .y        (y_top),
    .x_nxt    (x_top_nxt),
    .y_nxt    (y_top_nxt),
    .vy_nxt   (vy_top_nxt)
  );

  veggie_physics u_bot (
    .clk      (pixel_clk_in),
    .rst_n    (rst_in),
    .load     (load),
    .load_x   ({2'b00, launch_x_in}),
    .load_y   (LAUNCH_Y),
    .load_vx  (launch_vx_in),
    .load_vy  (launch_vy_in),
    .kick     (hit),
    .kick_dvx (SEP_POS),
    .step     (step),
    .x        (x_bot),
    .y        (y_bot),
    .x_nxt    (x_bot_nxt),
    .y_nxt    (y_bot_nxt),
    .vy_nxt   (vy_bot_nxt)
  );

  // Bottom-half high position bits only matter internally for the retire test.
  assign unused_bot_hi = ^{x_bot[POS_W-1:11], y_bot[POS_W-1:10]};

  assign x_top_out   = x_top[10:0];
  assign y_top_out   = y_top[9:0];
  assign x_bot_out   = x_bot[10:0];
  assign y_bot_out   = y_bot[9:0];
  assign whole_out   = whole_q;
  assign run_out     = run_q;
  assign rise_out    = rise_q;
  assign visible_out = visible_q;
  assign sliced_out  = sliced_q;
  assign gone_out    = gone_q;
  assign busy_out    = busy_q;

endmodule
